// File: rtl/comp_serial_nbit_if.sv
// Operand/result bundle for comp_serial_nbit: valid/ready operand input,
// valid/ready one-hot result output.
interface comp_serial_nbit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             ahigher;
  logic             alower;
  logic             asame;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out_valid, ahigher, alower, asame
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out_valid, ahigher, alower, asame
  );
endinterface

// File: rtl/comp_serial_nbit.sv
// Serial MSB-first magnitude comparator, DIGIT bits/clock, early exit; result after 1..WIDTH/DIGIT edges.
// Result held indefinitely until out_ready; operands accepted only in IDLE (one bubble after release).
module comp_serial_nbit #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter bit SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst,
  comp_serial_nbit_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("comp_serial_nbit: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       res_q, res_d;
  logic [DIGIT-1:0] dig_a, dig_b;

  assign dig_a = a_q[WIDTH-1 -: DIGIT];
  assign dig_b = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Flipping both sign bits turns two's-complement order into unsigned order.
          a_d            = bus.a;
          b_d            = bus.b;
          a_d[WIDTH-1]   = bus.a[WIDTH-1] ^ SIGNED;
          b_d[WIDTH-1]   = bus.b[WIDTH-1] ^ SIGNED;
          idx_d          = IW'(NDIG - 1);
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        if (dig_a > dig_b) begin
          res_d   = 3'b100;
          state_d = S_DONE;
        end else if (dig_a < dig_b) begin
          res_d   = 3'b010;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          res_d   = 3'b001;
          state_d = S_DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          res_d   = 3'b000;
          state_d = S_IDLE;
        end
      end
      default: begin
        res_d   = 3'b000;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
    a_q   <= a_d;
    b_q   <= b_d;
    idx_q <= idx_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign {bus.ahigher, bus.alower, bus.asame} = res_q;
endmodule
